cache_assoc_wb: RTL and testbench

Parametrised fully-associative, write-back, write-allocate cache with true-LRU replacement in front of an internal single-port backing RAM with configurable access latency. It is the next-generation memory-hierarchy block: generalises line count, address/data width and RAM latency, and adds a valid/ready request handshake, dirty-line write-back on eviction, and hit/miss statistics. It sits between the switch/display front-end and storage, one word per cache line.

---
 rtl/cache_assoc_wb.sv | 233 +++++++++++++++++++++++
 tb/tb_cache_assoc_wb.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_assoc_wb.sv
// Fully-associative write-back/write-allocate cache, true-LRU, one word per line,
// fronting an internal single-port backing RAM with RAM_LAT-cycle accesses.
module cache_assoc_wb #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int LINES   = 4,
    parameter int RAM_LAT = 3,
    parameter int CNT_W   = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_hit,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int IDX_W = $clog2(LINES);
    localparam int LAT_W = $clog2(RAM_LAT + 1);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE, WB, FILL, RESP} state_t;

    state_t                         state_q, state_d;
    logic [LAT_W-1:0]               cnt_q, cnt_d;
    logic                           wr_q, wr_d;
    logic [ADDR_W-1:0]              addr_q, addr_d;
    logic [DATA_W-1:0]              wdata_q, wdata_d;
    logic                           hit_q, hit_d;
    logic [IDX_W-1:0]               sel_q, sel_d;
    logic [DATA_W-1:0]              fill_q, fill_d;

    logic [LINES-1:0]               valid_q, valid_d;
    logic [LINES-1:0]               dirty_q, dirty_d;
    logic [LINES-1:0][ADDR_W-1:0]   tag_q, tag_d;
    logic [LINES-1:0][DATA_W-1:0]   data_q, data_d;
    logic [LINES-1:0][IDX_W-1:0]    age_q, age_d;

    logic                           resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]              resp_rdata_q, resp_rdata_d;
    logic                           resp_hit_q, resp_hit_d;
    logic [CNT_W-1:0]               hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]               miss_cnt_q, miss_cnt_d;

    logic                           hit_any, inv_any;
    logic [IDX_W-1:0]               hit_idx, inv_idx, lru_idx, vict_idx;
    logic                           vict_dirty;
    logic [IDX_W-1:0]               cur_age;

    logic                           ram_we;
    logic [ADDR_W-1:0]              ram_waddr;
    logic [DATA_W-1:0]              ram_wdata;
    logic [DATA_W-1:0]              ram_rdata;
    logic [DATA_W-1:0]              ram [DEPTH];

    // Storage holds data XOR address, so the all-zero power-up image reads back
    // as RAM[a] = a without any load step; reset never touches it.
    always_ff @(posedge clock) begin
        if (ram_we) ram[ram_waddr] <= ram_wdata ^ DATA_W'(ram_waddr);
    end
    assign ram_rdata = ram[addr_q] ^ DATA_W'(addr_q);

    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        inv_any = 1'b0;
        inv_idx = '0;
        lru_idx = '0;
        // Descending scan so the lowest-index invalid line wins.
        for (int i = LINES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                inv_any = 1'b1;
                inv_idx = IDX_W'(i);
            end
            if (age_q[i] == IDX_W'(LINES - 1)) lru_idx = IDX_W'(i);
            if (valid_q[i] && tag_q[i] == req_addr) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    assign vict_idx   = inv_any ? inv_idx : lru_idx;
    assign vict_dirty = valid_q[vict_idx] & dirty_q[vict_idx];
    assign cur_age    = age_q[sel_q];

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        hit_d        = hit_q;
        sel_d        = sel_q;
        fill_d       = fill_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        tag_d        = tag_q;
        data_d       = data_q;
        age_d        = age_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_hit_d   = resp_hit_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        ram_we       = 1'b0;
        ram_waddr    = tag_q[sel_q];
        ram_wdata    = data_q[sel_q];

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    wr_d    = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    hit_d   = hit_any;
                    sel_d   = hit_any ? hit_idx : vict_idx;
                    cnt_d   = '0;
                    if (hit_any)         state_d = RESP;
                    else if (vict_dirty) state_d = WB;
                    else if (!req_write) state_d = FILL;
                    else                 state_d = RESP;
                end
            end
            WB: begin
                if (cnt_q == LAT_W'(RAM_LAT - 1)) begin
                    ram_we  = 1'b1;
                    cnt_d   = '0;
                    state_d = wr_q ? RESP : FILL;
                end else begin
                    cnt_d = cnt_q + LAT_W'(1);
                end
            end
            FILL: begin
                if (cnt_q == LAT_W'(RAM_LAT - 1)) begin
                    fill_d  = ram_rdata;
                    cnt_d   = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + LAT_W'(1);
                end
            end
            RESP: begin
                state_d      = IDLE;
                resp_valid_d = 1'b1;
                resp_hit_d   = hit_q;
                resp_rdata_d = wr_q ? wdata_q : (hit_q ? data_q[sel_q] : fill_q);
                // Promote using the line's own age: for a valid victim that is
                // LINES-1, for an empty line it keeps the ages a permutation.
                for (int i = 0; i < LINES; i++) begin
                    if (age_q[i] < cur_age) age_d[i] = age_q[i] + IDX_W'(1);
                end
                age_d[sel_q] = '0;
                if (wr_q) begin
                    data_d[sel_q]  = wdata_q;
                    tag_d[sel_q]   = addr_q;
                    valid_d[sel_q] = 1'b1;
                    dirty_d[sel_q] = 1'b1;
                end else if (!hit_q) begin
                    data_d[sel_q]  = fill_q;
                    tag_d[sel_q]   = addr_q;
                    valid_d[sel_q] = 1'b1;
                    dirty_d[sel_q] = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == RESP && state_q != RESP) begin
            if (hit_d) begin
                if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_W'(1);
            end else begin
                if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            hit_q        <= 1'b0;
            sel_q        <= '0;
            fill_q       <= '0;
            valid_q      <= '0;
            dirty_q      <= '0;
            tag_q        <= '0;
            data_q       <= '0;
            for (int i = 0; i < LINES; i++) age_q[i] <= IDX_W'(i);
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_hit_q   <= 1'b0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            hit_q        <= hit_d;
            sel_q        <= sel_d;
            fill_q       <= fill_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
            tag_q        <= tag_d;
            data_q       <= data_d;
            age_q        <= age_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_hit_q   <= resp_hit_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_hit   = resp_hit_q;
    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_cache_assoc_wb.sv
// Scoreboard bench for cache_assoc_wb: directed accesses push expected responses,
// a negedge monitor pops and checks data, hit flag and response cycle.
module tb_cache_assoc_wb;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [7:0]  req_addr = '0;
    logic [7:0]  req_wdata = '0;
    logic        resp_valid;
    logic [7:0]  resp_rdata;
    logic        resp_hit;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    logic        s_req_valid = 1'b0;
    logic        s_req_ready;
    logic        s_req_write = 1'b0;
    logic [7:0]  s_req_addr = '0;
    logic [7:0]  s_req_wdata = '0;
    logic        s_resp_valid;
    logic [7:0]  s_resp_rdata;
    logic        s_resp_hit;
    logic [3:0]  s_hit_count;
    logic [3:0]  s_miss_count;

    cache_assoc_wb dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_hit(resp_hit),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    cache_assoc_wb #(.CNT_W(4)) dut_s (
        .clock(clock), .reset(reset),
        .req_valid(s_req_valid), .req_ready(s_req_ready), .req_write(s_req_write),
        .req_addr(s_req_addr), .req_wdata(s_req_wdata),
        .resp_valid(s_resp_valid), .resp_rdata(s_resp_rdata), .resp_hit(s_resp_hit),
        .hit_count(s_hit_count), .miss_count(s_miss_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] rdata;
        logic       hit;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   nvec = 0;
    int   nerr = 0;
    int   last_k = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    function automatic logic [7:0] ram_peek(input logic [7:0] a);
        return dut.ram[a] ^ a;
    endfunction

    always @(negedge clock) begin
        if (resp_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("resp_rdata", int'(resp_rdata), int'(mon_e.rdata));
                chk("resp_hit", int'(resp_hit), int'(mon_e.hit));
                chk("resp_cycle", cyc, mon_e.cyc);
            end
        end
    end

    task automatic issue(input logic w, input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] er, input logic eh, input int lat);
        int n = 0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        while (!req_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clock);
        #1;
        last_k = cyc;
        sb.push_back('{rdata: er, hit: eh, cyc: cyc + lat});
        req_valid = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] er, input logic eh, input int lat);
        issue(1'b0, a, 8'h00, er, eh, lat);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d, input logic eh, input int lat);
        issue(1'b1, a, d, d, eh, lat);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        chk({tag, "_resp_valid"}, int'(resp_valid), 0);
        chk({tag, "_resp_rdata"}, int'(resp_rdata), 0);
        chk({tag, "_resp_hit"}, int'(resp_hit), 0);
        chk({tag, "_hit_count"}, int'(hit_count), 0);
        chk({tag, "_miss_count"}, int'(miss_count), 0);
        chk({tag, "_req_ready"}, int'(req_ready), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    initial begin
        int k1;
        int n;

        // 1: read miss then read hit
        do_reset("rst1");
        rd(8'h10, 8'h10, 1'b0, 4);
        rd(8'h10, 8'h10, 1'b1, 1);
        // 2: write miss into empty line, read back, RAM untouched
        wr(8'h20, 8'hAB, 1'b0, 1);
        rd(8'h20, 8'hAB, 1'b1, 1);
        drain();
        chk("t2_ram20", int'(ram_peek(8'h20)), 8'h20);
        chk("t2_hits", int'(hit_count), 2);
        chk("t2_misses", int'(miss_count), 2);

        // 3: fill with dirty lines, LRU eviction with write-back
        do_reset("rst3");
        wr(8'h01, 8'hA1, 1'b0, 1);
        wr(8'h02, 8'hA2, 1'b0, 1);
        wr(8'h03, 8'hA3, 1'b0, 1);
        wr(8'h04, 8'hA4, 1'b0, 1);
        rd(8'h01, 8'hA1, 1'b1, 1);
        wr(8'h05, 8'hA5, 1'b0, 4);
        drain();
        chk("t3_ram02", int'(ram_peek(8'h02)), 8'hA2);
        rd(8'h02, 8'hA2, 1'b0, 7);
        drain();
        chk("t3_ram03", int'(ram_peek(8'h03)), 8'hA3);
        chk("t3_misses", int'(miss_count), 6);
        chk("t3_hits", int'(hit_count), 1);

        // 4: second request held during a read miss
        do_reset("rst4");
        rd(8'h30, 8'h30, 1'b0, 4);
        k1 = last_k;
        rd(8'h31, 8'h31, 1'b0, 4);
        chk("t4_accept_gap", last_k - k1, 5);
        drain();

        // 5: reset during the second write-back cycle
        do_reset("rst5");
        wr(8'h40, 8'h77, 1'b0, 1);
        wr(8'h41, 8'h78, 1'b0, 1);
        wr(8'h42, 8'h79, 1'b0, 1);
        wr(8'h43, 8'h7A, 1'b0, 1);
        drain();
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 8'h50;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk("t5_ram40", int'(ram_peek(8'h40)), 8'h40);
        chk("t5_resp_valid", int'(resp_valid), 0);
        chk("t5_resp_rdata", int'(resp_rdata), 0);
        chk("t5_resp_hit", int'(resp_hit), 0);
        chk("t5_hit_count", int'(hit_count), 0);
        chk("t5_miss_count", int'(miss_count), 0);
        chk("t5_req_ready", int'(req_ready), 1);
        repeat (8) @(negedge clock);
        chk("t5_ram40_later", int'(ram_peek(8'h40)), 8'h40);
        #1;
        rd(8'h40, 8'h40, 1'b0, 4);
        drain();

        // 6: saturating hit counter on a CNT_W=4 instance
        for (int i = 0; i < 21; i++) begin
            s_req_valid = 1'b1;
            s_req_write = 1'b0;
            s_req_addr  = 8'h55;
            @(posedge clock);
            #1;
            s_req_valid = 1'b0;
            n = 0;
            while (!s_resp_valid && n < 20) begin
                @(negedge clock);
                n++;
            end
            if (!s_resp_valid) chk("t6_resp_timeout", 0, 1);
            if (i == 15) chk("t6_hits_at_15", int'(s_hit_count), 15);
            @(negedge clock);
        end
        chk("t6_hits_sat", int'(s_hit_count), 15);
        chk("t6_misses", int'(s_miss_count), 1);
        chk("t6_last_rdata", int'(s_resp_rdata), 8'h55);
        chk("t6_last_hit", int'(s_resp_hit), 1);

        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
